poly_mul_lanes_stream: RTL and testbench
========================================

POLY_MUL_LANES_STREAM -- requirements
Module: poly_mul_lanes_stream

Interface
REQ-001 SHALL have parameter N, default 256, polynomial length; power of two, 16..256.
REQ-002 SHALL have parameter LANES, default 4, a-coefficients consumed per MAC cycle; one of 1, 2, 4.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled in IDLE only
- accumulate  in  1  sampled with start; 1 = keep accumulator, 0 = clear it
- s_valid  in  1  secret word valid
- s_ready  out  1  secret word accepted when high with s_valid
- s_data  in  64  16 secret coefficients; coefficient 16w+m in bits 4m+3:4m
- a_valid  in  1  a word valid
- a_ready  out  1  a word accepted when high with a_valid
- a_data  in  64  4 a coefficients; coefficient 4w+m in bits 16m+12:16m; bits 16m+15:16m+13 ignored
- res_valid  out  1  result word valid
- res_ready  in  1  result word accepted when high with res_valid
- res_data  out  64  4 result coefficients, each zero-extended to 16 bits; coefficient 4w+m in bits 16m+15:16m
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the operation completes

Function
REQ-005 SHALL compute acc = acc_init + a*s in Z_8192[x]/(x^N+1).
- acc_init is 0 when accumulate=0.
- acc_init is the previous accumulator contents when accumulate=1.
REQ-006 Secret coefficients SHALL be 4-bit sign-magnitude: bit3 is the sign, bits 2:0 the magnitude; 0x8 is 0.
REQ-007 All accumulator arithmetic SHALL be 13-bit modulo 2^13, with wrap and no saturation.
REQ-008 The state machine SHALL have exactly these states: IDLE, LOAD_S, MAC, OUT.
REQ-009 IDLE: start=1 SHALL go to LOAD_S; start in any other state SHALL be ignored.
REQ-010 LOAD_S: s_ready=1; SHALL accept N/16 words in index order, then go to MAC on the cycle after the last handshake.
REQ-011 MAC state, rotating secret register:
- SHALL hold the rotating secret register r, initialised to s.
- Each MAC cycle processes coefficients a_j..a_{j+LANES-1}.
- For each lane l in order: acc_k += a_{j+l}*r_k for all k, then r <- x*r.
- x*r means r_k <- r_{k-1}, and r_0 <- r_{N-1} with its sign bit flipped.
REQ-012 MAC state, input handshake:
- a_ready SHALL be high when the holding register is empty, or on the last processing cycle of the current word.
- An accepted word SHALL be processed over 4/LANES consecutive cycles.
- With no word held, the block SHALL stall: acc and r unchanged.
REQ-013 After N coefficients are processed, the block SHALL go to OUT; a_ready SHALL be 0 outside MAC.
REQ-014 OUT: res_valid=1, presenting words 0..N/4-1 in order.
- res_data SHALL be held stable while res_ready=0.
- The block SHALL advance on each handshake.
REQ-015 After the last result handshake the block SHALL go to IDLE and pulse done for exactly one cycle.
REQ-016 Throughput, with no stalls: N/16 + N/LANES + N/4 cycles from start to the last result word. For N=256, LANES=4: 16+64+64.
REQ-017 accumulate=1 with no prior operation since reset SHALL use the zero accumulator.

Reset
REQ-018 rst low SHALL force IDLE asynchronously, including mid-operation, and clear acc, r and the holding register.
REQ-019 During reset, outputs SHALL be: s_ready=0, a_ready=0, res_valid=0, res_data=0, busy=0, done=0.
REQ-020 The first start after rst is released SHALL behave as after power-up.

Configuration
REQ-021 Macro POLY_MUL_PERF_CNT_EN controls a cycle counter:
- Defined: adds output port perf_cycles (16 bits, out).
- perf_cycles counts cycles from start acceptance to the done pulse, saturating at 0xFFFF.
- perf_cycles holds its value until the next start, and resets to 0.
- Undefined: the port and the counter are absent, with no other behavioural difference.

Verification
REQ-022 Identity: s coefficient 0 = 0x1, others 0; a_k = k; accumulate=0 -> result coefficient k = k for all k, then done.
REQ-023 Negacyclic wrap: s coefficient 1 = 0x1; a_255=5, others 0; N=256 -> result coefficient 0 = 0x1FFB, others 0.
REQ-024 Sign and modulus:
- s coefficient 0 = 0xB (-3); a_0=1 -> result coefficient 0 = 0x1FFD.
- s coefficient 0 = 0x7; a_0=0x1FFF -> result coefficient 0 = 0x1FF9.
REQ-025 Accumulate: repeat REQ-022 with accumulate=1 -> result coefficient k = 2k mod 8192; a third run with accumulate=0 -> k.
REQ-026 Backpressure:
- Stimulus: random a_valid gaps, res_ready low for 7 cycles mid-OUT, start pulsed in MAC.
- Response: results identical to REQ-022; res_data held stable while stalled; exactly N/4 result words; a single done.
REQ-027 Reset mid-MAC: rst low for 1 cycle -> busy=0 and all outputs at reset values; a following REQ-022 run is correct; with POLY_MUL_PERF_CNT_EN and no stalls, perf_cycles=144 for N=256, LANES=4.

Source files
------------

// File: rtl/poly_mul_lanes_stream.sv
// rtl/poly_mul_lanes_stream.sv - negacyclic poly multiply-accumulate in Z_8192[x]/(x^N+1), LANES a-coefficients per cycle; optional POLY_MUL_PERF_CNT_EN cycle counter
module poly_mul_lanes_stream #(
  parameter int N     = 256,
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        accumulate,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [63:0] a_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        busy,
  output logic        done
`ifdef POLY_MUL_PERF_CNT_EN
  ,
  output logic [15:0] perf_cycles
`endif
);

  localparam logic [7:0] S_LAST = 8'(N / 16 - 1);
  localparam logic [7:0] W_LAST = 8'(N / 4 - 1);
  localparam logic [1:0] K_LAST = 2'(4 / LANES - 1);

  typedef enum logic [1:0] {IDLE, LOAD_S, MAC, OUT} state_e;

  state_e      state_q;
  logic [7:0]  sidx_q, wcnt_q, ridx_q;
  logic        hold_valid_q;
  logic [63:0] hold_q;
  logic [1:0]  ph_q;
  logic        done_q;

  logic [12:0] acc_q [N];
  logic [3:0]  r_q   [N];
  logic [12:0] acc_d [N];
  logic [3:0]  r_d   [N];

  logic        mac_active, last_chunk, a_ready_w;
  logic [1:0]  chunk;
  logic [63:0] word;
  logic [12:0] lane_coef, prod;
  logic [3:0]  wrap;
  logic        unused_pad_bits;

  // Word under processing comes straight from the input when nothing is held,
  // so a freshly accepted word starts its first chunk without a bubble.
  assign chunk      = hold_valid_q ? ph_q : 2'd0;
  assign word       = hold_valid_q ? hold_q : a_data;
  assign last_chunk = (chunk == K_LAST);
  assign mac_active = (state_q == MAC) && (hold_valid_q || a_valid);
  assign a_ready_w  = (state_q == MAC) &&
                      (!hold_valid_q || ((ph_q == K_LAST) && (wcnt_q != W_LAST)));

  assign s_ready   = (state_q == LOAD_S);
  assign a_ready   = a_ready_w;
  assign res_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  assign unused_pad_bits = ^{a_data[63:61], a_data[47:45], a_data[31:29], a_data[15:13],
                             hold_q[63:61], hold_q[47:45], hold_q[31:29], hold_q[15:13]};

  // Control FSM: sequencing, holding register and word/result counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sidx_q       <= '0;
      wcnt_q       <= '0;
      ridx_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      ph_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= LOAD_S;
            sidx_q       <= '0;
            wcnt_q       <= '0;
            ridx_q       <= '0;
            hold_valid_q <= 1'b0;
            ph_q         <= '0;
          end
        end
        LOAD_S: begin
          if (s_valid) begin
            if (sidx_q == S_LAST) state_q <= MAC;
            else sidx_q <= sidx_q + 8'd1;
          end
        end
        MAC: begin
          if (hold_valid_q) begin
            if (ph_q == K_LAST) begin
              if (a_valid && a_ready_w) begin
                hold_q <= a_data;
                ph_q   <= 2'd0;
              end else begin
                hold_valid_q <= 1'b0;
              end
            end else begin
              ph_q <= ph_q + 2'd1;
            end
          end else if (a_valid && (K_LAST != 2'd0)) begin
            hold_valid_q <= 1'b1;
            hold_q       <= a_data;
            ph_q         <= 2'd1;
          end
          if (mac_active && last_chunk) begin
            if (wcnt_q == W_LAST) state_q <= OUT;
            else wcnt_q <= wcnt_q + 8'd1;
          end
        end
        OUT: begin
          if (res_ready) begin
            if (ridx_q == W_LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              ridx_q <= ridx_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One MAC cycle: each lane adds a*r into every coefficient, then multiplies r by x
  always_comb begin
    lane_coef = '0;
    prod      = '0;
    wrap      = '0;
    for (int k = 0; k < N; k++) begin
      acc_d[k] = acc_q[k];
      r_d[k]   = r_q[k];
    end
    for (int l = 0; l < LANES; l++) begin
      lane_coef = '0;
      for (int m = 0; m < 4; m++) begin
        if (m == int'(chunk) * LANES + l) lane_coef = word[16*m +: 13];
      end
      for (int k = 0; k < N; k++) begin
        prod     = lane_coef * {10'd0, r_d[k][2:0]};
        acc_d[k] = r_d[k][3] ? (acc_d[k] - prod) : (acc_d[k] + prod);
      end
      wrap = r_d[N-1] ^ 4'h8;
      for (int k = N - 1; k > 0; k--) r_d[k] = r_d[k-1];
      r_d[0] = wrap;
    end
  end

  // Accumulator and rotating secret register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
        r_q[k]   <= '0;
      end
    end else begin
      if ((state_q == IDLE) && start && !accumulate) begin
        for (int k = 0; k < N; k++) acc_q[k] <= '0;
      end
      if ((state_q == LOAD_S) && s_valid) begin
        for (int k = 0; k < N; k++) begin
          if (k / 16 == int'(sidx_q)) r_q[k] <= s_data[4*(k%16) +: 4];
        end
      end
      if (mac_active) begin
        for (int k = 0; k < N; k++) begin
          acc_q[k] <= acc_d[k];
          r_q[k]   <= r_d[k];
        end
      end
    end
  end

  // Result word selection, zero outside OUT
  always_comb begin
    res_data = '0;
    if (state_q == OUT) begin
      for (int k = 0; k < N; k++) begin
        if (k / 4 == int'(ridx_q)) res_data[16*(k%4) +: 16] = {3'b000, acc_q[k]};
      end
    end
  end

`ifdef POLY_MUL_PERF_CNT_EN
  logic [15:0] perf_q;

  // Saturating busy-cycle counter, restarted by each accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      perf_q <= '0;
    end else if ((state_q != IDLE) && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_poly_mul_lanes_stream.sv
// tb/tb_poly_mul_lanes_stream.sv - self-checking bench for poly_mul_lanes_stream against a direct negacyclic product model
module tb_poly_mul_lanes_stream;

  localparam int N     = 256;
  localparam int LANES = 4;
  localparam int THRU  = N / 16 + N / LANES + N / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, accumulate;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic        a_valid, a_ready;
  logic [63:0] a_data;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic        busy, done;
`ifdef POLY_MUL_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif

  poly_mul_lanes_stream #(.N(N), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done)
`ifdef POLY_MUL_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0]  s_coef [N];
  logic [12:0] a_coef [N];
  logic [2:0]  a_pad  [N];
  logic [12:0] got    [N];
  int          macc   [N];
  int nwords, ndone, last_cyc, unstable, bad_upper;

  function automatic logic [63:0] s_word(input int w);
    logic [63:0] v = '0;
    if (w < N / 16) for (int m = 0; m < 16; m++) v[4*m +: 4] = s_coef[16*w + m];
    return v;
  endfunction

  function automatic logic [63:0] a_word(input int w);
    logic [63:0] v = '0;
    if (w < N / 4) for (int m = 0; m < 4; m++) v[16*m +: 16] = {a_pad[4*w + m], a_coef[4*w + m]};
    return v;
  endfunction

  function automatic int mism();
    for (int k = 0; k < N; k++) if (got[k] !== macc[k][12:0]) return k;
    return -1;
  endfunction

  // Reference: schoolbook product with x^N = -1, sign-magnitude secret, mod 8192
  task automatic model_apply(input bit acc_en);
    int sv, idx, term;
    if (!acc_en) for (int k = 0; k < N; k++) macc[k] = 0;
    for (int i = 0; i < N; i++) begin
      if (a_coef[i] != 0) begin
        for (int j = 0; j < N; j++) begin
          sv = int'(s_coef[j][2:0]);
          if (s_coef[j][3]) sv = -sv;
          if (sv != 0) begin
            idx  = i + j;
            term = int'(a_coef[i]) * sv;
            if (idx >= N) begin
              idx  = idx - N;
              term = -term;
            end
            macc[idx] = (macc[idx] + term) & 8191;
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) begin
      s_coef[k] = 4'h0;
      a_coef[k] = 13'h0;
      a_pad[k]  = 3'($urandom);
    end
  endtask

  task automatic set_identity();
    clear_inputs();
    s_coef[0] = 4'h1;
    for (int k = 0; k < N; k++) a_coef[k] = 13'(k);
  endtask

  // Drives one full operation; fires are predicted at negedge from registered ready/valid
  task automatic run_op(input bit acc_en, input bit gaps, input bit stall,
                        input bit start_mac, input int abort_ai);
    int si, ai, ri, stall_cnt, after_done;
    bit stalled_prev;
    logic [63:0] held;
    nwords = 0; ndone = 0; last_cyc = -1; unstable = 0; bad_upper = 0;
    si = 0; ai = 0; ri = 0; stall_cnt = 0; after_done = -1; stalled_prev = 0; held = '0;
    for (int k = 0; k < N; k++) got[k] = 13'h0;
    @(negedge clk);
    start = 1'b1; accumulate = acc_en;
    s_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (abort_ai >= 0 && ai == abort_ai) break;
      start = 1'b0;
      accumulate = 1'($urandom);
      if (start_mac && a_ready && ai == 4) start = 1'b1;
      if (done) ndone++;
      s_valid = (si < N / 16) && (!gaps || $urandom_range(0, 3) != 0);
      s_data  = s_word(si);
      if (s_valid && s_ready) si++;
      a_valid = (ai < N / 4) && (!gaps || $urandom_range(0, 2) != 0);
      a_data  = a_word(ai);
      if (a_valid && a_ready) ai++;
      if (stall && ri == N / 8 && stall_cnt < 7) begin
        res_ready = 1'b0;
        stall_cnt++;
      end else begin
        res_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (res_valid && stalled_prev && res_data !== held) unstable++;
      stalled_prev = res_valid && !res_ready;
      held = res_data;
      if (res_valid && res_ready) begin
        for (int m = 0; m < 4; m++) begin
          if (4*ri + m < N) got[4*ri + m] = res_data[16*m +: 13];
          if (res_data[16*m + 13 +: 3] != 3'b000) bad_upper++;
        end
        ri++; nwords++; last_cyc = cyc;
      end
      if (ndone > 0 && after_done < 0) after_done = cyc;
      if (after_done >= 0 && cyc > after_done + 3) break;
    end
    start = 1'b0; s_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; accumulate = 1'b0;
    s_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0; s_data = '0; a_data = '0;
    #12;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (s_ready !== 1'b0)   begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (a_ready !== 1'b0)   begin failures++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 64'd0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef POLY_MUL_PERF_CNT_EN
    checks++; if (perf_cycles !== 16'd0) begin failures++; $display("FAIL reset_perf got=%0d exp=0", perf_cycles); end
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_identity();
    int m;
    set_identity();
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b0);
    m = mism();
    checks++; if (m != -1) begin failures++; $display("FAIL identity coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
    checks++; if (got[77] !== 13'd77) begin failures++; $display("FAIL identity_c77 got=%0d exp=77", got[77]); end
    checks++; if (nwords != N / 4) begin failures++; $display("FAIL identity_words got=%0d exp=%0d", nwords, N / 4); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL identity_done got=%0d exp=1", ndone); end
    checks++; if (last_cyc != THRU) begin failures++; $display("FAIL throughput got=%0d exp=%0d", last_cyc, THRU); end
    checks++; if (bad_upper != 0) begin failures++; $display("FAIL identity_zero_ext got=%0d exp=0", bad_upper); end
`ifdef POLY_MUL_PERF_CNT_EN
    checks++; if (perf_cycles !== 16'(THRU)) begin failures++; $display("FAIL perf_identity got=%0d exp=%0d", perf_cycles, THRU); end
`endif
  endtask

  task automatic test_negacyclic();
    int m;
    clear_inputs();
    s_coef[1] = 4'h1;
    a_coef[N-1] = 13'd5;
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b0);
    m = mism();
    checks++; if (got[0] !== 13'h1FFB) begin failures++; $display("FAIL negacyclic_c0 got=%h exp=1ffb", got[0]); end
    checks++; if (m != -1) begin failures++; $display("FAIL negacyclic coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
  endtask

  task automatic test_sign_modulus();
    int m;
    clear_inputs();
    s_coef[0] = 4'hB;
    a_coef[0] = 13'd1;
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b0);
    m = mism();
    checks++; if (got[0] !== 13'h1FFD) begin failures++; $display("FAIL sign_c0 got=%h exp=1ffd", got[0]); end
    checks++; if (m != -1) begin failures++; $display("FAIL sign coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
    clear_inputs();
    s_coef[0] = 4'h7;
    a_coef[0] = 13'h1FFF;
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b0);
    m = mism();
    checks++; if (got[0] !== 13'h1FF9) begin failures++; $display("FAIL modulus_c0 got=%h exp=1ff9", got[0]); end
    checks++; if (m != -1) begin failures++; $display("FAIL modulus coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
  endtask

  task automatic test_accumulate();
    int m;
    set_identity();
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b1);
    m = mism();
    checks++; if (got[255] !== 13'd510) begin failures++; $display("FAIL accumulate_c255 got=%0d exp=510", got[255]); end
    checks++; if (m != -1) begin failures++; $display("FAIL accumulate coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
    run_op(1'b0, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b0);
    m = mism();
    checks++; if (got[255] !== 13'd255) begin failures++; $display("FAIL clear_c255 got=%0d exp=255", got[255]); end
    checks++; if (m != -1) begin failures++; $display("FAIL clear coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
  endtask

  task automatic test_backpressure();
    int m;
    set_identity();
    run_op(1'b0, 1'b1, 1'b1, 1'b1, -1);
    model_apply(1'b0);
    m = mism();
    checks++; if (m != -1) begin failures++; $display("FAIL backpressure coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
    checks++; if (nwords != N / 4) begin failures++; $display("FAIL backpressure_words got=%0d exp=%0d", nwords, N / 4); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL backpressure_done got=%0d exp=1", ndone); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL backpressure_stable got=%0d exp=0", unstable); end
  endtask

  task automatic test_reset_mid_mac();
    int m;
    set_identity();
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 5);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if ({s_ready, a_ready, res_valid, done, res_data} !== 68'd0) begin
      failures++; $display("FAIL midreset_outputs got=%b%b%b%b_%h exp=0", s_ready, a_ready, res_valid, done, res_data);
    end
`ifdef POLY_MUL_PERF_CNT_EN
    checks++; if (perf_cycles !== 16'd0) begin failures++; $display("FAIL midreset_perf got=%0d exp=0", perf_cycles); end
`endif
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < N; k++) macc[k] = 0;
    run_op(1'b1, 1'b0, 1'b0, 1'b0, -1);
    model_apply(1'b1);
    m = mism();
    checks++; if (m != -1) begin failures++; $display("FAIL after_reset coef=%0d got=%h exp=%h", m, got[m], macc[m][12:0]); end
    checks++; if (last_cyc != THRU) begin failures++; $display("FAIL after_reset_thru got=%0d exp=%0d", last_cyc, THRU); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL after_reset_done got=%0d exp=1", ndone); end
`ifdef POLY_MUL_PERF_CNT_EN
    checks++; if (perf_cycles !== 16'd144) begin failures++; $display("FAIL perf_cycles got=%0d exp=144", perf_cycles); end
`endif
  endtask

  task automatic test_random();
    int m;
    bit acc_en;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < N; k++) begin
        s_coef[k] = 4'($urandom);
        a_coef[k] = 13'($urandom);
        a_pad[k]  = 3'($urandom);
      end
      acc_en = (it > 0) ? 1'($urandom) : 1'b0;
      run_op(acc_en, it[0], 1'b0, 1'b0, -1);
      model_apply(acc_en);
      m = mism();
      checks++; if (m != -1) begin failures++; $display("FAIL random%0d coef=%0d got=%h exp=%h", it, m, got[m], macc[m][12:0]); end
      checks++; if (nwords != N / 4) begin failures++; $display("FAIL random%0d_words got=%0d exp=%0d", it, nwords, N / 4); end
      checks++; if (ndone != 1) begin failures++; $display("FAIL random%0d_done got=%0d exp=1", it, ndone); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL random%0d_stable got=%0d exp=0", it, unstable); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_negacyclic();
    test_sign_modulus();
    test_accumulate();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
